// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the in-order
// pipeline writeback and a long-latency unit (mul/div) whose results wait in
// a small FIFO. The pipeline normally wins. A FIFO head that has waited
// STARVE_LIMIT cycles is force-granted, and the pipeline is stalled for that cycle.
// Optional feature macro: WB_ARB_BYPASS_EN. When it is defined, an LLU result
// that arrives into an empty FIFO with no live pipeline write is granted
// directly, without being enqueued.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_i_wen,
    input  logic [4:0]  pipe_i_rd,
    input  logic [63:0] pipe_i_data,
    input  logic        llu_i_valid,
    input  logic [4:0]  llu_i_rd,
    input  logic [63:0] llu_i_data,
    output logic        llu_o_ready,
    output logic        arb_o_stall,
    output logic        rf_o_wen,
    output logic [4:0]  rf_o_rd,
    output logic [63:0] rf_o_data
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

    // LLU result storage; only the pointers and count carry reset
    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [63:0]   fifo_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [3:0]    starve_q, starve_d;
    logic          rf_wen_q, rf_wen_d;
    logic [4:0]    rf_rd_q,  rf_rd_d;
    logic [63:0]   rf_data_q, rf_data_d;

    logic fifo_empty;
    logic fifo_full;
    logic pipe_live;
    logic llu_xfer;
    logic head_starved;
    logic bypass;
    logic push;
    logic pop;
    logic grant_pipe;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == FULL_CNT);
    // A write to x0 is architecturally a no-op, so it never competes for the port
    assign pipe_live    = pipe_i_wen && (pipe_i_rd != 5'd0);
    assign llu_xfer     = llu_i_valid && !fifo_full;
    assign head_starved = !fifo_empty && (starve_q == STARVE_MAX);

`ifdef WB_ARB_BYPASS_EN
    assign bypass = llu_xfer && fifo_empty && !pipe_live;
`else
    assign bypass = 1'b0;
`endif

    assign push        = llu_xfer && !bypass;
    // The head is granted when it is starved, or when the pipeline has nothing live
    assign pop         = head_starved || (!pipe_live && !fifo_empty);
    assign grant_pipe  = pipe_live && !head_starved;

    assign llu_o_ready = !fifo_full;
    assign arb_o_stall = head_starved && pipe_live;
    assign rf_o_wen    = rf_wen_q;
    assign rf_o_rd     = rf_rd_q;
    assign rf_o_data   = rf_data_q;

    // Next-state: grant selection, FIFO bookkeeping and starvation tracking
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        rf_wen_d  = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;

        if (pop) begin
            rf_wen_d  = (fifo_rd_q[rd_ptr_q] != 5'd0);
            rf_rd_d   = fifo_rd_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
            rd_ptr_d  = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end else if (grant_pipe) begin
            rf_wen_d  = 1'b1;
            rf_rd_d   = pipe_i_rd;
            rf_data_d = pipe_i_data;
        end else if (bypass) begin
            rf_wen_d  = (llu_i_rd != 5'd0);
            rf_rd_d   = llu_i_rd;
            rf_data_d = llu_i_data;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // The counter measures how long the current head has waited
        if (pop || fifo_empty) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Control state and the registered write port, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= 4'd0;
            rf_wen_q  <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= 64'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            rf_wen_q  <= rf_wen_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // FIFO payload write; stale slots are harmless because count_q gates reads
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            fifo_rd_q[wr_ptr_q]   <= llu_i_rd;
            fifo_data_q[wr_ptr_q] <= llu_i_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: a queue-level model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_i_wen = 1'b0;
    logic [4:0]  pipe_i_rd = 5'd0;
    logic [63:0] pipe_i_data = 64'd0;
    logic        llu_i_valid = 1'b0;
    logic [4:0]  llu_i_rd = 5'd0;
    logic [63:0] llu_i_data = 64'd0;
    logic        llu_o_ready;
    logic        arb_o_stall;
    logic        rf_o_wen;
    logic [4:0]  rf_o_rd;
    logic [63:0] rf_o_data;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_i_wen(pipe_i_wen), .pipe_i_rd(pipe_i_rd), .pipe_i_data(pipe_i_data),
        .llu_i_valid(llu_i_valid), .llu_i_rd(llu_i_rd), .llu_i_data(llu_i_data),
        .llu_o_ready(llu_o_ready), .arb_o_stall(arb_o_stall),
        .rf_o_wen(rf_o_wen), .rf_o_rd(rf_o_rd), .rf_o_data(rf_o_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Queue-level model: list of waiting LLU results, head at index 0
    typedef struct {
        logic [4:0]  qrd [8];
        logic [63:0] qdat [8];
        int          n;
        int          wait_cnt;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] dat;
    } model_t;

    model_t m;

    function automatic model_t model_clear();
        model_t r;
        for (int i = 0; i < 8; i++) begin
            r.qrd[i] = 5'd0;
            r.qdat[i] = 64'd0;
        end
        r.n = 0; r.wait_cnt = 0; r.wen = 1'b0; r.rd = 5'd0; r.dat = 64'd0;
        return r;
    endfunction

    function automatic model_t model_step(model_t cur, logic pw, logic [4:0] prd, logic [63:0] pdat,
                                          logic lv, logic [4:0] lrd, logic [63:0] ldat);
        model_t r = cur;
        bit live    = pw && (prd != 5'd0);
        bit starved = (cur.n > 0) && (cur.wait_cnt == STARVE_LIMIT);
        bit accept  = lv && (cur.n < DEPTH);
        bit popped  = 1'b0;
        r.wen = 1'b0;
        if (starved || (!live && cur.n > 0)) begin
            r.wen = (cur.qrd[0] != 5'd0);
            r.rd  = cur.qrd[0];
            r.dat = cur.qdat[0];
            for (int i = 0; i < 7; i++) begin
                r.qrd[i]  = r.qrd[i+1];
                r.qdat[i] = r.qdat[i+1];
            end
            r.n--;
            popped = 1'b1;
        end else if (live) begin
            r.wen = 1'b1; r.rd = prd; r.dat = pdat;
        end else if (BYP && accept && cur.n == 0) begin
            r.wen = (lrd != 5'd0); r.rd = lrd; r.dat = ldat;
            accept = 1'b0;
        end
        if (accept) begin
            r.qrd[r.n]  = lrd;
            r.qdat[r.n] = ldat;
            r.n++;
        end
        if (popped || cur.n == 0) r.wait_cnt = 0;
        else if (cur.wait_cnt < STARVE_LIMIT) r.wait_cnt = cur.wait_cnt + 1;
        return r;
    endfunction

    // Model advances on the same edges as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_clear();
        else m <= model_step(m, pipe_i_wen, pipe_i_rd, pipe_i_data, llu_i_valid, llu_i_rd, llu_i_data);
    end

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (started) begin
            check("mdl_ready", 64'(llu_o_ready), 64'(m.n < DEPTH));
            check("mdl_stall", 64'(arb_o_stall),
                  64'(rst_n && m.n > 0 && m.wait_cnt == STARVE_LIMIT && pipe_i_wen && pipe_i_rd != 5'd0));
            check("mdl_wen", 64'(rf_o_wen), 64'(m.wen));
            if (m.wen) begin
                check("mdl_rd", 64'(rf_o_rd), 64'(m.rd));
                check("mdl_data", rf_o_data, m.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic pw, input logic [4:0] prd, input logic [63:0] pdat,
                          input logic lv, input logic [4:0] lrd, input logic [63:0] ldat);
        pipe_i_wen = pw; pipe_i_rd = prd; pipe_i_data = pdat;
        llu_i_valid = lv; llu_i_rd = lrd; llu_i_data = ldat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] order [3];
    int         pushed;
    int         n_llu;
    int         acc3;
    bit         stale_seen;

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66);   // must be ignored in reset
        tick();
        check("rst_wen", 64'(rf_o_wen), 64'd0);
        check("rst_rd", 64'(rf_o_rd), 64'd0);
        check("rst_data", rf_o_data, 64'd0);
        check("rst_stall", 64'(arb_o_stall), 64'd0);
        check("rst_ready", 64'(llu_o_ready), 64'd1);
        tick();
        started = 1'b1;
        rst_n = 1'b1;
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();
        check("post_rst_empty_wen", 64'(rf_o_wen), 64'd0);
        tick();
        check("post_rst_empty_wen2", 64'(rf_o_wen), 64'd0);

        // Pipeline-only write
        set_in(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        #1 check("pipe_stall", 64'(arb_o_stall), 64'd0);
        tick();
        check("pipe_wen", 64'(rf_o_wen), 64'd1);
        check("pipe_rd", 64'(rf_o_rd), 64'd5);
        check("pipe_data", rf_o_data, 64'hAA);
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();
        check("idle_wen", 64'(rf_o_wen), 64'd0);

        // Contention: pipeline wins until the head has waited STARVE_LIMIT cycles
        set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h77);
        #1 check("cont_ready", 64'(llu_o_ready), 64'd1);
        tick();
        check("cont_c0_rd", 64'(rf_o_rd), 64'd3);
        set_in(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
        for (int j = 1; j <= 4; j++) begin
            #1 check("cont_nostall", 64'(arb_o_stall), 64'd0);
            tick();
            check("cont_pipe_rd", 64'(rf_o_rd), 64'd3);
        end
        #1 check("cont_stall", 64'(arb_o_stall), 64'd1);
        tick();
        check("cont_llu_wen", 64'(rf_o_wen), 64'd1);
        check("cont_llu_rd", 64'(rf_o_rd), 64'd7);
        check("cont_llu_data", rf_o_data, 64'h77);
        #1 check("cont_cleared", 64'(arb_o_stall), 64'd0);
        tick();
        check("cont_after_rd", 64'(rf_o_rd), 64'd3);
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();

        // Full FIFO with the pipeline saturated: three results offered back-to-back
        pushed = 0; n_llu = 0; acc3 = -1;
        for (int c = 0; c < 40; c++) begin
            if (pushed < 3) set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'(10 + pushed), 64'h101 + 64'(pushed));
            else            set_in(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
            #1;
            if (c == 2) check("full_ready_low", 64'(llu_o_ready), 64'd0);
            if (llu_o_ready && llu_i_valid) begin
                if (pushed == 2) acc3 = c;
                pushed++;
            end
            tick();
            if (rf_o_wen && rf_o_rd >= 5'd10 && rf_o_rd <= 5'd12 && n_llu < 3) begin
                order[n_llu] = rf_o_rd;
                n_llu++;
            end
            if (n_llu == 3) break;
        end
        check("full_count", 64'(n_llu), 64'd3);
        check("full_acc3_cycle", 64'(acc3), 64'd6);
        if (n_llu == 3) begin
            check("full_order0", 64'(order[0]), 64'd10);
            check("full_order1", 64'(order[1]), 64'd11);
            check("full_order2", 64'(order[2]), 64'd12);
        end
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();
        tick();

        // Pipeline write to x0 lets the FIFO head through without a stall
        set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h99);
        tick();
        set_in(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
        #1 check("rd0_stall", 64'(arb_o_stall), 64'd0);
        tick();
        check("rd0_wen", 64'(rf_o_wen), 64'd1);
        check("rd0_rd", 64'(rf_o_rd), 64'd9);
        check("rd0_data", rf_o_data, 64'h99);
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();

        // LLU entry targeting x0 is popped but not written
        set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd0, 64'hDEAD);
        tick();
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();
        check("llu_rd0_wen", 64'(rf_o_wen), 64'd0);
        #1 check("llu_rd0_popped", 64'(llu_o_ready), 64'd1);
        tick();

        // Latency of a lone LLU result
        set_in(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'h44);
        tick();
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        check("lat_edge1_wen", 64'(rf_o_wen), 64'(BYP));
        tick();
        check("lat_edge2_wen", 64'(rf_o_wen), 64'(!BYP));
        check("lat_rd", 64'(rf_o_rd), 64'd4);
        check("lat_data", rf_o_data, 64'h44);
        tick();

        // Reset mid-run discards queued results
        set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd20, 64'h200);
        tick();
        set_in(1'b1, 5'd3, 64'h33, 1'b1, 5'd21, 64'h201);
        tick();
        check("mid_pre_wen", 64'(rf_o_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen", 64'(rf_o_wen), 64'd0);
        check("mid_rst_stall", 64'(arb_o_stall), 64'd0);
        check("mid_rst_ready", 64'(llu_o_ready), 64'd1);
        tick();
        tick();
        set_in(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        rst_n = 1'b1;
        stale_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rf_o_wen && (rf_o_rd == 5'd20 || rf_o_rd == 5'd21)) stale_seen = 1'b1;
        end
        check("mid_no_stale", 64'(stale_seen), 64'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
